// File: rtl/uart_apb_ctrl.sv
// APB slave sequencer for the UART datapath: decodes register selects, issues write/TX/RX
// strobes and stalls PREADY until the UART completes or the wait times out.
module uart_apb_ctrl #(
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [1:0]    tr_mode,
    input  logic          tx_done,
    input  logic          rx_valid,
    output logic          sel_ops,
    output logic          sel_tr,
    output logic          sel_mode,
    output logic          sel_baud,
    output logic          write_control,
    output logic          tx_start,
    output logic          rx_ack,
    output logic          pready,
    output logic          pslverr,
    output logic          busy
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LastCnt = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StAccess, StTxWait, StRxWait, StResp} state_e;

    state_e          state_q, state_d;
    state_e          tgt_q, tgt_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      sel_q, sel_d;
    logic            wc_q, wc_d;
    logic            tx_q, tx_d;
    logic            rx_ack_q, rx_ack_d;
    logic            pready_q, pready_d;
    logic            pslverr_q, pslverr_d;
    logic            busy_q, busy_d;
    logic [3:0]      dec_sel;
    logic            timeout_hit;

    // Select bit order: {ops, tr, mode, baud}
    always_comb begin
        dec_sel = {paddr == AW'(8'h00), paddr == AW'(8'h04),
                   paddr == AW'(8'h08), paddr == AW'(8'h10)};
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == LastCnt);

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        wc_d      = 1'b0;
        tx_d      = 1'b0;
        rx_ack_d  = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_d = '0;
                if (psel && !penable) begin
                    state_d = StAccess;
                    sel_d   = dec_sel;
                    tgt_d   = StResp;
                    err_d   = 1'b0;
                    if (dec_sel == 4'b0000) begin
                        err_d = 1'b1;
                    end else if (dec_sel[3]) begin
                        if (pwrite && tr_mode == 2'b01) begin
                            tgt_d = StTxWait;
                            wc_d  = 1'b1;
                            tx_d  = 1'b1;
                        end else if (!pwrite && tr_mode == 2'b10) begin
                            tgt_d = StRxWait;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        wc_d = pwrite;
                    end
                end
            end
            StAccess: begin
                if (!psel) begin
                    state_d = StIdle;
                    sel_d   = '0;
                end else begin
                    state_d = tgt_q;
                    cnt_d   = '0;
                    if (tgt_q == StResp) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                    end
                end
            end
            StTxWait, StRxWait: begin
                if (!psel) begin
                    state_d = StIdle;
                    sel_d   = '0;
                end else if ((state_q == StTxWait && tx_done) ||
                             (state_q == StRxWait && rx_valid)) begin
                    // Completion wins over a coincident timeout
                    state_d  = StResp;
                    pready_d = 1'b1;
                    rx_ack_d = (state_q == StRxWait);
                end else if (timeout_hit) begin
                    state_d   = StResp;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                sel_d   = '0;
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            tgt_q     <= StResp;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            sel_q     <= '0;
            wc_q      <= 1'b0;
            tx_q      <= 1'b0;
            rx_ack_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            wc_q      <= wc_d;
            tx_q      <= tx_d;
            rx_ack_q  <= rx_ack_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            busy_q    <= busy_d;
        end
    end

    assign sel_ops       = sel_q[3];
    assign sel_tr        = sel_q[2];
    assign sel_mode      = sel_q[1];
    assign sel_baud      = sel_q[0];
    assign write_control = wc_q;
    assign tx_start      = tx_q;
    assign rx_ack        = rx_ack_q;
    assign pready        = pready_q;
    assign pslverr       = pslverr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: hand-written vector table plus randomized transactions checked
// against a transaction-level model of the APB sequencing rules.
module tb_uart_apb_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       psel, penable, pwrite;
    logic [7:0] paddr;
    logic [1:0] tr_mode;
    logic       tx_done, rx_valid;

    logic a_ops, a_tr, a_mode, a_baud, a_wc, a_tx, a_rxa, a_rdy, a_err, a_busy;
    logic b_ops, b_tr, b_mode, b_baud, b_wc, b_tx, b_rxa, b_rdy, b_err, b_busy;
    logic [9:0] o_a, o_b;

    assign o_a = {a_ops, a_tr, a_mode, a_baud, a_wc, a_tx, a_rxa, a_rdy, a_err, a_busy};
    assign o_b = {b_ops, b_tr, b_mode, b_baud, b_wc, b_tx, b_rxa, b_rdy, b_err, b_busy};

    uart_apb_ctrl #(.AW(8), .TIMEOUT(1024)) dut (
        .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .tr_mode(tr_mode), .tx_done(tx_done), .rx_valid(rx_valid),
        .sel_ops(a_ops), .sel_tr(a_tr), .sel_mode(a_mode), .sel_baud(a_baud),
        .write_control(a_wc), .tx_start(a_tx), .rx_ack(a_rxa), .pready(a_rdy),
        .pslverr(a_err), .busy(a_busy)
    );

    uart_apb_ctrl #(.AW(8), .TIMEOUT(16)) dut16 (
        .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .tr_mode(tr_mode), .tx_done(tx_done), .rx_valid(rx_valid),
        .sel_ops(b_ops), .sel_tr(b_tr), .sel_mode(b_mode), .sel_baud(b_baud),
        .write_control(b_wc), .tx_start(b_tx), .rx_ack(b_rxa), .pready(b_rdy),
        .pslverr(b_err), .busy(b_busy)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic use16    = 1'b0;
    int   tmo      = 1024;

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [1:0] mode;
        logic [3:0] sel;
        logic       wc;
        logic       tx;
        int         wt;
        logic       err;
        int         da;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [9:0] ov(input logic [3:0] s, input logic wc, input logic tx,
                                      input logic ra, input logic pr, input logic pe,
                                      input logic b);
        return {s, wc, tx, ra, pr, pe, b};
    endfunction

    task automatic chk(input string nm, input logic [9:0] exp);
        logic [9:0] got;
        got = use16 ? o_b : o_a;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (sel4,wc,tx,rxack,pready,pslverr,busy)",
                     nm, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic e, input logic w, input logic [7:0] a,
                        input logic td, input logic rv);
        psel = s; penable = e; pwrite = w; paddr = a; tx_done = td; rx_valid = rv;
        @(posedge clk);
        #1;
    endtask

    // Rules model: what an access to (addr, dir, tr_mode) should do
    function automatic void model(input logic [7:0] a, input logic w, input logic [1:0] m,
                                  output logic [3:0] s, output logic wc, output logic tx,
                                  output int wt, output logic err);
        logic [7:0] map [4];
        map = '{8'h00, 8'h04, 8'h08, 8'h10};
        s = '0;
        for (int i = 0; i < 4; i++) if (a == map[i]) s[3-i] = 1'b1;
        wt = 0;
        if (a == 8'h00) begin
            if (w && m == 2'b01) wt = 1;
            else if (!w && m == 2'b10) wt = 2;
        end
        err = (s == 4'b0000) || (s[3] && wt == 0);
        wc  = w && !err;
        tx  = (wt == 1);
    endfunction

    // One APB transfer; da = wait cycle of completion (-1 never), ab = step of psel drop
    task automatic run_txn(input string nm, input logic [7:0] a, input logic w,
                           input logic [3:0] es, input logic ewc, input logic etx,
                           input int ewt, input logic eerr, input int da, input int ab);
        logic comp, td, rv;
        step(1'b1, 1'b0, w, a, 1'($urandom), 1'($urandom));
        chk({nm, ".access"}, ov(es, ewc, etx, 1'b0, 1'b0, 1'b0, 1'b1));
        if (ab == 1) begin
            step(1'b0, 1'b0, w, a, 1'b0, 1'b0);
            chk({nm, ".abort_access"}, '0);
            return;
        end
        step(1'b1, 1'b1, w, a, 1'($urandom), 1'($urandom));
        if (ewt == 0) begin
            chk({nm, ".resp"}, ov(es, 1'b0, 1'b0, 1'b0, 1'b1, eerr, 1'b1));
            step(1'b1, 1'b1, w, a, 1'($urandom), 1'($urandom));
            chk({nm, ".idle_after"}, '0);
            return;
        end
        chk({nm, ".wait_entry"}, ov(es, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int j = 0; j < 2000; j++) begin
            if (ab == j + 2) begin
                step(1'b0, 1'b0, w, a, 1'b0, 1'b0);
                chk({nm, ".abort_wait"}, '0);
                return;
            end
            comp = (j == da);
            td = (ewt == 1) ? comp : 1'($urandom);
            rv = (ewt == 2) ? comp : 1'($urandom);
            step(1'b1, 1'b1, w, a, td, rv);
            if (comp || (tmo != 0 && j == tmo - 1)) begin
                if (comp) chk({nm, ".done"}, ov(es, 1'b0, 1'b0, ewt == 2, 1'b1, 1'b0, 1'b1));
                else      chk({nm, ".timeout"}, ov(es, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
                step(1'b1, 1'b1, w, a, 1'b0, 1'b0);
                chk({nm, ".idle_after"}, '0);
                return;
            end
            chk({nm, ".waiting"}, ov(es, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s.bound: wait loop exhausted, got no response", nm);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("reset_async", '0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset_hold", '0);
        rstn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic       w;
        logic [1:0] m;
        logic [3:0] es;
        logic       ewc, etx, eerr;
        int         ewt, da, ab, gaps;

        tbl[0]  = '{8'h10, 1'b1, 2'b00, 4'b0001, 1'b1, 1'b0, 0, 1'b0, -1};
        tbl[1]  = '{8'h0C, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 0, 1'b1, -1};
        tbl[2]  = '{8'h00, 1'b1, 2'b11, 4'b1000, 1'b0, 1'b0, 0, 1'b1, -1};
        tbl[3]  = '{8'h04, 1'b1, 2'b11, 4'b0100, 1'b1, 1'b0, 0, 1'b0, -1};
        tbl[4]  = '{8'h08, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0, 0, 1'b0, -1};
        tbl[5]  = '{8'h00, 1'b1, 2'b01, 4'b1000, 1'b1, 1'b1, 1, 1'b0, 3};
        tbl[6]  = '{8'h00, 1'b0, 2'b10, 4'b1000, 1'b0, 1'b0, 2, 1'b0, 0};
        tbl[7]  = '{8'h00, 1'b0, 2'b01, 4'b1000, 1'b0, 1'b0, 0, 1'b1, -1};
        tbl[8]  = '{8'h00, 1'b1, 2'b10, 4'b1000, 1'b0, 1'b0, 0, 1'b1, -1};
        tbl[9]  = '{8'h00, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0, 0, 1'b1, -1};
        tbl[10] = '{8'hFF, 1'b1, 2'b01, 4'b0000, 1'b0, 1'b0, 0, 1'b1, -1};
        tbl[11] = '{8'h08, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b0, 0, 1'b0, -1};

        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        tr_mode = 2'b00; tx_done = 1'b0; rx_valid = 1'b0;
        do_reset();
        // Missing setup phase must not start a transfer
        step(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1);
        chk("penable_in_idle", '0);

        // Entries 2 and 3 run back-to-back with no idle cycle between them
        for (int i = 0; i < 12; i++) begin
            tr_mode = tbl[i].mode;
            run_txn($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].sel, tbl[i].wc,
                    tbl[i].tx, tbl[i].wt, tbl[i].err, tbl[i].da, -1);
        end

        tr_mode = 2'b01;
        run_txn("tx20", 8'h00, 1'b1, 4'b1000, 1'b1, 1'b1, 1, 1'b0, 19, -1);

        use16 = 1'b1; tmo = 16; tr_mode = 2'b10;
        run_txn("rx_timeout16", 8'h00, 1'b0, 4'b1000, 1'b0, 1'b0, 2, 1'b0, -1, -1);
        run_txn("rx_at_expiry", 8'h00, 1'b0, 4'b1000, 1'b0, 1'b0, 2, 1'b0, 15, -1);

        use16 = 1'b0; tmo = 1024;
        do_reset();
        run_txn("rx_abort", 8'h00, 1'b0, 4'b1000, 1'b0, 1'b0, 2, 1'b0, -1, 4);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rx_abort_quiet", '0);

        // Asynchronous reset landing mid TX_WAIT
        tr_mode = 2'b01;
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("midrst.access", ov(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("midrst.wait", ov(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        #2;
        do_reset();

        use16 = 1'b1; tmo = 16;
        for (int n = 0; n < 150; n++) begin
            case ($urandom % 6)
                0: a = 8'h00;
                1: a = 8'h04;
                2: a = 8'h08;
                3: a = 8'h10;
                4: a = 8'h00;
                default: a = 8'($urandom);
            endcase
            w = 1'($urandom);
            m = 2'($urandom);
            model(a, w, m, es, ewc, etx, ewt, eerr);
            da = ($urandom % 5 == 0) ? -1 : int'($urandom_range(0, 20));
            ab = ($urandom % 8 == 0) ? ((ewt != 0) ? int'($urandom_range(1, 6)) : 1) : -1;
            tr_mode = m;
            run_txn($sformatf("rnd%0d", n), a, w, es, ewc, etx, ewt, eerr, da, ab);
            gaps = $urandom % 3;
            for (int g = 0; g < gaps; g++) begin
                w = 1'($urandom);
                step(w, w ? 1'b1 : 1'($urandom), 1'($urandom), 8'($urandom),
                     1'($urandom), 1'($urandom));
                chk($sformatf("rnd%0d.gap", n), '0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
